// File: rtl/aes_stim_ctrl_if.sv
// Stimulus/result bundle between aes_stim_ctrl and the host plus AES core.
// master = the controller, slave = the host/core side.
interface aes_stim_ctrl_if #(
    parameter int unsigned STATE_BITS = 128,
    parameter int unsigned KEY_BITS   = 128,
    parameter int unsigned COUNT_BITS = 32
);
    logic                  start;
    logic [COUNT_BITS-1:0] num_tests;
    logic                  pause;
    logic [STATE_BITS-1:0] state_o;
    logic [KEY_BITS-1:0]   key_o;
    logic                  issue_o;
    logic [STATE_BITS-1:0] ct_i;
    logic                  busy;
    logic                  done;
    logic [STATE_BITS-1:0] signature;
    logic [COUNT_BITS-1:0] tests_issued;
    logic [COUNT_BITS-1:0] results_captured;

    modport master (
        input  start, num_tests, pause, ct_i,
        output state_o, key_o, issue_o, busy, done, signature, tests_issued, results_captured
    );

    modport slave (
        output start, num_tests, pause, ct_i,
        input  state_o, key_o, issue_o, busy, done, signature, tests_issued, results_captured
    );
endinterface

// File: rtl/aes_stim_ctrl.sv
// LFSR stimulus generator and MISR signature compactor for the pipelined AES cores.
// Issues num_tests vectors, tracks them through LATENCY cycles, folds each ciphertext.
module aes_stim_ctrl #(
    parameter int unsigned           STATE_BITS = 128,
    parameter int unsigned           KEY_BITS   = 128,
    parameter int unsigned           LATENCY    = 21,
    parameter int unsigned           COUNT_BITS = 32,
    parameter logic [STATE_BITS-1:0] STATE_SEED = {4{32'hDEAD_BEEF}},
    parameter logic [KEY_BITS-1:0]   KEY_SEED   = {(KEY_BITS / 32){32'hCAFE_FEED}},
    parameter bit                    KEY_HOLD   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_stim_ctrl_if.master bus
);

    if (STATE_BITS != 128) begin : g_bad_state_bits
        $error("aes_stim_ctrl: STATE_BITS must be 128");
    end
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_stim_ctrl: KEY_BITS must be 128, 192 or 256");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("aes_stim_ctrl: LATENCY must be at least 1");
    end

    // Key LFSR taps (1-indexed); the first tap is always the MSB.
    localparam int unsigned KT2 = (KEY_BITS == 128) ? 126 : (KEY_BITS == 192) ? 190 : 254;
    localparam int unsigned KT3 = (KEY_BITS == 128) ? 101 : (KEY_BITS == 192) ? 178 : 251;
    localparam int unsigned KT4 = (KEY_BITS == 128) ? 99  : (KEY_BITS == 192) ? 177 : 246;

    localparam logic [STATE_BITS-1:0] MISR_POLY = STATE_BITS'(8'h87);
    localparam logic [COUNT_BITS-1:0] ONE       = COUNT_BITS'(1);

    typedef enum logic [1:0] {StIdle, StSeed, StRun, StDrain} fsm_e;

    fsm_e                  r_fsm;
    fsm_e                  w_fsm_nxt;
    logic [COUNT_BITS-1:0] r_num;
    logic [COUNT_BITS-1:0] r_issued;
    logic [COUNT_BITS-1:0] r_captured;
    logic [STATE_BITS-1:0] r_sig;
    logic [STATE_BITS-1:0] r_lfsr_st;
    logic [KEY_BITS-1:0]   r_lfsr_key;
    logic [LATENCY-1:0]    r_valid;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_capture;
    logic                  w_finish;
    logic [LATENCY-1:0]    w_valid_nxt;
    logic [STATE_BITS-1:0] w_st_step;
    logic [KEY_BITS-1:0]   w_key_step;
    logic [STATE_BITS-1:0] w_sig_step;

    assign w_accept  = (r_fsm == StIdle) && bus.start;
    // Gated directly by pause so a pause in cycle c suppresses that cycle's issue.
    assign w_issue   = (r_fsm == StRun) && !bus.pause && (r_issued != r_num);
    assign w_capture = r_valid[LATENCY-1];
    assign w_finish  = ((r_fsm == StSeed) && (r_num == '0)) ||
                       ((r_fsm == StDrain) && (w_fsm_nxt == StIdle));

    assign w_valid_nxt = (r_valid << 1) | LATENCY'(w_issue);

    assign w_st_step  = {r_lfsr_st[STATE_BITS-2:0],
                         ~(r_lfsr_st[127] ^ r_lfsr_st[125] ^ r_lfsr_st[100] ^ r_lfsr_st[98])};
    assign w_key_step = {r_lfsr_key[KEY_BITS-2:0],
                         ~(r_lfsr_key[KEY_BITS-1] ^ r_lfsr_key[KT2-1] ^
                           r_lfsr_key[KT3-1] ^ r_lfsr_key[KT4-1])};
    assign w_sig_step = {r_sig[STATE_BITS-2:0], 1'b0} ^
                        (r_sig[STATE_BITS-1] ? MISR_POLY : '0) ^ bus.ct_i;

    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            StIdle:  if (bus.start) w_fsm_nxt = StSeed;
            StSeed:  w_fsm_nxt = (r_num == '0) ? StIdle : StRun;
            // Equality on issued+1 avoids wrap when num_tests is all ones.
            StRun:   if (w_issue && (r_issued + ONE == r_num)) w_fsm_nxt = StDrain;
            StDrain: if ((r_valid == '0) && (r_captured == r_num)) w_fsm_nxt = StIdle;
            default: w_fsm_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm      <= StIdle;
            r_num      <= '0;
            r_issued   <= '0;
            r_captured <= '0;
            r_sig      <= '0;
            r_done     <= 1'b0;
            r_valid    <= '0;
            r_lfsr_st  <= STATE_SEED;
            r_lfsr_key <= KEY_SEED;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_valid <= w_valid_nxt;

            if (w_accept) begin
                r_num      <= bus.num_tests;
                r_issued   <= '0;
                r_captured <= '0;
                r_sig      <= '0;
                r_done     <= 1'b0;
            end else begin
                if (w_issue) r_issued <= r_issued + ONE;
                if (w_capture) begin
                    r_captured <= r_captured + ONE;
                    r_sig      <= w_sig_step;
                end
                if (w_finish) r_done <= 1'b1;
            end

            if (r_fsm == StSeed) begin
                r_lfsr_st  <= STATE_SEED;
                r_lfsr_key <= KEY_SEED;
            end else if (w_issue) begin
                r_lfsr_st <= w_st_step;
                if (!KEY_HOLD) r_lfsr_key <= w_key_step;
            end
        end
    end

    assign bus.state_o          = r_lfsr_st;
    assign bus.key_o            = r_lfsr_key;
    assign bus.issue_o          = w_issue;
    assign bus.busy             = (r_fsm != StIdle);
    assign bus.done             = r_done;
    assign bus.signature        = r_sig;
    assign bus.tests_issued     = r_issued;
    assign bus.results_captured = r_captured;

endmodule

// File: tb/tb_aes_stim_ctrl.sv
// Directed bench for aes_stim_ctrl: a default 128-bit-key instance and a 256-bit KEY_HOLD one,
// each fed by an ideal core whose ciphertext is state ^ key[127:0] after LATENCY cycles.
module tb_aes_stim_ctrl;

    localparam int L0 = 21;
    localparam int L1 = 4;
    localparam logic [127:0] SSEED    = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] KSEED    = {4{32'hCAFE_FEED}};
    localparam logic [255:0] KSEED256 = {8{32'hCAFE_FEED}};
    // Seed ^ key seed, hand-computed per 32-bit word: DEADBEEF ^ CAFEFEED.
    localparam logic [127:0] CT_FIRST = {4{32'h1453_4002}};
    // One XNOR step of the 128-bit LFSR from the seed, hand-computed.
    localparam logic [127:0] ST_SECOND = {4{32'hBD5B_7DDF}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    aes_stim_ctrl_if #(.KEY_BITS(128)) bus0 ();
    aes_stim_ctrl_if #(.KEY_BITS(256)) bus1 ();

    aes_stim_ctrl #(.LATENCY(L0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    aes_stim_ctrl #(.KEY_BITS(256), .LATENCY(L1), .KEY_HOLD(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [127:0] core0 [L0];
    logic [127:0] core1 [L1];
    always_ff @(posedge clk) begin
        core0[0] <= bus0.state_o ^ bus0.key_o;
        for (int i = 1; i < L0; i++) core0[i] <= core0[i-1];
        core1[0] <= bus1.state_o ^ bus1.key_o[127:0];
        for (int i = 1; i < L1; i++) core1[i] <= core1[i-1];
    end
    assign bus0.ct_i = core0[L0-1];
    assign bus1.ct_i = core1[L1-1];

    function automatic logic [127:0] lfsr_step(input logic [127:0] r);
        return {r[126:0], ~(r[127] ^ r[125] ^ r[100] ^ r[98])};
    endfunction

    function automatic logic [127:0] model_sig(input int n, input bit hold);
        logic [127:0] s, k, sig;
        s = SSEED;
        k = KSEED;
        sig = '0;
        for (int i = 0; i < n; i++) begin
            sig = {sig[126:0], 1'b0} ^ (sig[127] ? 128'h87 : 128'h0) ^ (s ^ k);
            s = lfsr_step(s);
            if (!hold) k = lfsr_step(k);
        end
        return sig;
    endfunction

    // Results of the last run0 call.
    int           rr_edges, rr_issues, rr_held, rr_first, rr_last;
    logic [127:0] rr_st0, rr_st1, rr_k0;

    // Runs one job on instance 0. rr_edges counts clock edges after the edge that took start.
    task automatic run0(input int n, input int p_lo, input int p_hi, input bit poke);
        logic [127:0] prev;
        bit           prev_paused;
        int           e;
        rr_issues = 0; rr_held = 0; rr_first = -1; rr_last = -1;
        rr_st0 = '0; rr_st1 = '0; rr_k0 = '0;
        prev = '0; prev_paused = 1'b0;
        @(posedge clk); #1;
        bus0.num_tests = n;
        bus0.start     = 1'b1;
        e = -1;
        while (e < 400) begin
            @(posedge clk); #1;
            e++;
            bus0.start     = 1'b0;
            bus0.num_tests = n;
            bus0.pause     = (e >= p_lo) && (e <= p_hi);
            if (poke && (e == 10 || e == n + 6)) begin
                bus0.start     = 1'b1;
                bus0.num_tests = 99;
            end
            #1;
            if (prev_paused && bus0.state_o == prev) rr_held++;
            prev_paused = bus0.pause && bus0.busy && !bus0.issue_o;
            if (bus0.issue_o) begin
                if (rr_issues == 0) begin rr_st0 = bus0.state_o; rr_k0 = bus0.key_o; rr_first = e; end
                if (rr_issues == 1) rr_st1 = bus0.state_o;
                rr_issues++;
                rr_last = e;
            end
            prev = bus0.state_o;
            if (bus0.done && !bus0.busy) break;
        end
        rr_edges = e;
        bus0.start = 1'b0;
        bus0.pause = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;
        n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        n_tests++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus0.done); end
        n_tests++; if (bus0.issue_o !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b want 0", bus0.issue_o); end
        n_tests++; if (bus0.tests_issued !== 32'd0) begin n_fail++; $display("FAIL reset_issued: got %0d want 0", bus0.tests_issued); end
        n_tests++; if (bus0.results_captured !== 32'd0) begin n_fail++; $display("FAIL reset_captured: got %0d want 0", bus0.results_captured); end
        n_tests++; if (bus0.signature !== 128'h0) begin n_fail++; $display("FAIL reset_sig: got %h want 0", bus0.signature); end
        n_tests++; if (bus0.state_o !== SSEED) begin n_fail++; $display("FAIL reset_state: got %h want %h", bus0.state_o, SSEED); end
        n_tests++; if (bus0.key_o !== KSEED) begin n_fail++; $display("FAIL reset_key: got %h want %h", bus0.key_o, KSEED); end
        n_tests++; if (bus1.key_o !== KSEED256) begin n_fail++; $display("FAIL reset_key256: got %h want %h", bus1.key_o, KSEED256); end
    endtask

    task automatic test_single();
        run0(1, -1, -2, 1'b0);
        n_tests++; if (rr_issues !== 1) begin n_fail++; $display("FAIL single_issues: got %0d want 1", rr_issues); end
        n_tests++; if (rr_st0 !== SSEED) begin n_fail++; $display("FAIL single_state: got %h want %h", rr_st0, SSEED); end
        n_tests++; if (rr_k0 !== KSEED) begin n_fail++; $display("FAIL single_key: got %h want %h", rr_k0, KSEED); end
        n_tests++; if (rr_edges !== L0 + 3) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", rr_edges, L0 + 3); end
        n_tests++; if (bus0.signature !== CT_FIRST) begin n_fail++; $display("FAIL single_sig: got %h want %h", bus0.signature, CT_FIRST); end
        n_tests++; if (bus0.results_captured !== 32'd1) begin n_fail++; $display("FAIL single_captured: got %0d want 1", bus0.results_captured); end
    endtask

    task automatic test_zero();
        run0(0, -1, -2, 1'b0);
        n_tests++; if (rr_edges !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1", rr_edges); end
        n_tests++; if (rr_issues !== 0) begin n_fail++; $display("FAIL zero_issues: got %0d want 0", rr_issues); end
        n_tests++; if (bus0.signature !== 128'h0) begin n_fail++; $display("FAIL zero_sig: got %h want 0", bus0.signature); end
        n_tests++; if (bus0.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", bus0.done); end
    endtask

    task automatic test_run50();
        run0(50, -1, -2, 1'b0);
        n_tests++; if (rr_issues !== 50) begin n_fail++; $display("FAIL run50_issues: got %0d want 50", rr_issues); end
        n_tests++; if (rr_last - rr_first + 1 !== 50) begin n_fail++; $display("FAIL run50_consecutive: span %0d want 50", rr_last - rr_first + 1); end
        n_tests++; if (rr_st1 !== ST_SECOND) begin n_fail++; $display("FAIL run50_state2: got %h want %h", rr_st1, ST_SECOND); end
        n_tests++; if (rr_edges !== 50 + L0 + 2) begin n_fail++; $display("FAIL run50_length: got %0d want %0d", rr_edges, 50 + L0 + 2); end
        n_tests++; if (bus0.signature !== model_sig(50, 1'b0)) begin n_fail++; $display("FAIL run50_sig: got %h want %h", bus0.signature, model_sig(50, 1'b0)); end
        n_tests++; if (bus0.results_captured !== 32'd50) begin n_fail++; $display("FAIL run50_captured: got %0d want 50", bus0.results_captured); end
    endtask

    task automatic test_pause();
        run0(50, 5, 9, 1'b0);
        n_tests++; if (rr_issues !== 50) begin n_fail++; $display("FAIL pause_issues: got %0d want 50", rr_issues); end
        n_tests++; if (rr_held !== 5) begin n_fail++; $display("FAIL pause_held: got %0d want 5", rr_held); end
        n_tests++; if (rr_edges !== 55 + L0 + 2) begin n_fail++; $display("FAIL pause_length: got %0d want %0d", rr_edges, 55 + L0 + 2); end
        n_tests++; if (bus0.signature !== model_sig(50, 1'b0)) begin n_fail++; $display("FAIL pause_sig: got %h want %h", bus0.signature, model_sig(50, 1'b0)); end
    endtask

    task automatic test_reset_mid_run();
        int issues;
        issues = 0;
        @(posedge clk); #1;
        bus0.num_tests = 100;
        bus0.start     = 1'b1;
        for (int c = 0; c < 60 && issues < 10; c++) begin
            @(posedge clk); #1;
            bus0.start = 1'b0;
            #1;
            if (bus0.issue_o) issues++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_tests++; if (issues !== 10) begin n_fail++; $display("FAIL midrst_reach: got %0d want 10", issues); end
        n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus0.busy); end
        n_tests++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus0.done); end
        n_tests++; if (bus0.tests_issued !== 32'd0) begin n_fail++; $display("FAIL midrst_issued: got %0d want 0", bus0.tests_issued); end
        n_tests++; if (bus0.signature !== 128'h0) begin n_fail++; $display("FAIL midrst_sig: got %h want 0", bus0.signature); end
        n_tests++; if (bus0.state_o !== SSEED) begin n_fail++; $display("FAIL midrst_state: got %h want %h", bus0.state_o, SSEED); end
        run0(3, -1, -2, 1'b0);
        n_tests++; if (rr_edges !== 3 + L0 + 2) begin n_fail++; $display("FAIL midrst_rerun_len: got %0d want %0d", rr_edges, 3 + L0 + 2); end
        n_tests++; if (bus0.results_captured !== 32'd3) begin n_fail++; $display("FAIL midrst_rerun_cap: got %0d want 3", bus0.results_captured); end
        n_tests++; if (bus0.signature !== model_sig(3, 1'b0)) begin n_fail++; $display("FAIL midrst_rerun_sig: got %h want %h", bus0.signature, model_sig(3, 1'b0)); end
    endtask

    task automatic test_back_to_back();
        run0(20, -1, -2, 1'b1);
        n_tests++; if (bus0.tests_issued !== 32'd20) begin n_fail++; $display("FAIL poke_issued: got %0d want 20", bus0.tests_issued); end
        n_tests++; if (bus0.results_captured !== 32'd20) begin n_fail++; $display("FAIL poke_captured: got %0d want 20", bus0.results_captured); end
        n_tests++; if (rr_edges !== 20 + L0 + 2) begin n_fail++; $display("FAIL poke_length: got %0d want %0d", rr_edges, 20 + L0 + 2); end
        n_tests++; if (bus0.signature !== model_sig(20, 1'b0)) begin n_fail++; $display("FAIL poke_sig: got %h want %h", bus0.signature, model_sig(20, 1'b0)); end
        run0(20, -1, -2, 1'b0);
        n_tests++; if (rr_issues !== 20) begin n_fail++; $display("FAIL rerun_issues: got %0d want 20", rr_issues); end
        n_tests++; if (bus0.signature !== model_sig(20, 1'b0)) begin n_fail++; $display("FAIL rerun_sig: got %h want %h", bus0.signature, model_sig(20, 1'b0)); end
    endtask

    task automatic test_key_hold();
        logic [127:0] s;
        int e, issues, key_bad, st_bad;
        s = SSEED; issues = 0; key_bad = 0; st_bad = 0;
        @(posedge clk); #1;
        bus1.num_tests = 20;
        bus1.start     = 1'b1;
        e = -1;
        while (e < 400) begin
            @(posedge clk); #1;
            e++;
            bus1.start = 1'b0;
            #1;
            if (bus1.key_o !== KSEED256) key_bad++;
            if (bus1.issue_o) begin
                if (bus1.state_o !== s) st_bad++;
                s = lfsr_step(s);
                issues++;
            end
            if (bus1.done && !bus1.busy) break;
        end
        n_tests++; if (issues !== 20) begin n_fail++; $display("FAIL hold_issues: got %0d want 20", issues); end
        n_tests++; if (key_bad !== 0) begin n_fail++; $display("FAIL hold_key: %0d cycles off seed, want 0", key_bad); end
        n_tests++; if (st_bad !== 0) begin n_fail++; $display("FAIL hold_state_seq: %0d bad states, want 0", st_bad); end
        n_tests++; if (e !== 20 + L1 + 2) begin n_fail++; $display("FAIL hold_length: got %0d want %0d", e, 20 + L1 + 2); end
        n_tests++; if (bus1.signature !== model_sig(20, 1'b1)) begin n_fail++; $display("FAIL hold_sig: got %h want %h", bus1.signature, model_sig(20, 1'b1)); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.pause = 1'b0; bus0.num_tests = '0;
        bus1.start = 1'b0; bus1.pause = 1'b0; bus1.num_tests = '0;
        test_reset();
        test_single();
        test_zero();
        test_run50();
        test_pause();
        test_reset_mid_run();
        test_back_to_back();
        test_key_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
